// File: rtl/parking_gate_pkg.sv
// Shared lane-state encoding, lane output bundle and default timing constants
// for the parking gate controller.
package parking_gate_pkg;

  localparam int unsigned DEF_DEBOUNCE     = 4;
  localparam int unsigned DEF_OPEN_TIMEOUT = 1000;
  localparam int unsigned DEF_PULSE_CYCLES = 2;
  localparam int unsigned DEF_CLOSE_HOLD   = 8;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned REJECT_CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPEN    = 3'd1,
    PASSING = 3'd2,
    EVENT   = 3'd3,
    CLOSE   = 3'd4,
    REJECT  = 3'd5
  } lane_state_e;

  typedef struct packed {
    logic barrier;
    logic evt;
    logic is_uni;
    logic reject;
  } lane_out_t;

endpackage

// File: rtl/gate_lane.sv
// One barrier lane: arrive/pass debouncers, badge qualification, barrier FSM
// and a shared saturating phase timer. All lane outputs are registered.
module gate_lane
  import parking_gate_pkg::*;
#(
  parameter int unsigned DEBOUNCE     = DEF_DEBOUNCE,
  parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned CLOSE_HOLD   = DEF_CLOSE_HOLD,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      arrive_i,
  input  logic      pass_i,
  input  logic      badge_valid_i,
  input  logic      badge_is_uni_i,
  input  logic      uni_vac_i,
  input  logic      pub_vac_i,
  output lane_out_t lane_o
);

  // bit 0: arrive loop, bit 1: pass loop
  logic [1:0]            raw;
  logic [1:0]            deb_q, deb_d;
  logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d, tmr_inc;
  logic             cls_q, cls_d;
  logic             pass_prev_q;
  logic             barrier_q, barrier_d;
  logic             evt_q, evt_d;
  logic             uni_q, uni_d;
  logic             rej_q, rej_d;
  logic             arrive, pass, pass_rise, pass_fall;

  assign raw = {pass_i, arrive_i};

  // Debounce: count consecutive disagreeing cycles, flip once the run is long enough.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (raw[i] != deb_q[i]) begin
        if ((db_cnt_q[i] + CNT_W'(1)) >= CNT_W'(DEBOUNCE)) begin
          deb_d[i] = raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_q       <= '0;
      db_cnt_q    <= '0;
      pass_prev_q <= 1'b0;
    end else begin
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      pass_prev_q <= deb_q[1];
    end
  end

  assign arrive    = deb_q[0];
  assign pass      = deb_q[1];
  assign pass_rise = pass & ~pass_prev_q;
  assign pass_fall = ~pass & pass_prev_q;
  assign tmr_inc   = (tmr_q == '1) ? tmr_q : tmr_q + CNT_W'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_inc;
    cls_d     = cls_q;
    uni_d     = uni_q;
    barrier_d = 1'b0;
    evt_d     = 1'b0;
    rej_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (badge_valid_i && arrive) begin
          cls_d   = badge_is_uni_i;
          state_d = (badge_is_uni_i ? uni_vac_i : pub_vac_i) ? OPEN : REJECT;
        end
      end
      OPEN: begin
        if (pass_rise) begin
          state_d = PASSING;
        end else if (tmr_inc >= CNT_W'(OPEN_TIMEOUT)) begin
          state_d = CLOSE;
        end
      end
      PASSING: begin
        if (pass_fall) begin
          state_d = EVENT;
        end
      end
      EVENT: begin
        if (tmr_inc >= CNT_W'(PULSE_CYCLES)) begin
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (tmr_inc >= CNT_W'(CLOSE_HOLD)) begin
          state_d = IDLE;
        end
      end
      REJECT: begin
        if (!arrive) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every phase measures its own duration from zero.
    if (state_d != state_q || state_d == IDLE) begin
      tmr_d = '0;
    end

    // Qualifier leads the pulse by the whole PASSING phase and holds through CLOSE.
    if (state_d == PASSING && state_q != PASSING) begin
      uni_d = cls_q;
    end
    if (state_d == IDLE) begin
      uni_d = 1'b0;
    end

    barrier_d = (state_d == OPEN) || (state_d == PASSING) || (state_d == EVENT);
    evt_d     = (state_d == EVENT);
    rej_d     = (state_d == REJECT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      cls_q     <= 1'b0;
      uni_q     <= 1'b0;
      barrier_q <= 1'b0;
      evt_q     <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cls_q     <= cls_d;
      uni_q     <= uni_d;
      barrier_q <= barrier_d;
      evt_q     <= evt_d;
      rej_q     <= rej_d;
    end
  end

  assign lane_o.barrier = barrier_q;
  assign lane_o.evt     = evt_q;
  assign lane_o.is_uni  = uni_q;
  assign lane_o.reject  = rej_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lane controller top: entrance and exit gate_lane instances.
// Optional GATE_REJECT_CNT_EN adds a saturating reject_count output.
module parking_gate_ctrl
  import parking_gate_pkg::*;
#(
  parameter int unsigned DEBOUNCE     = DEF_DEBOUNCE,
  parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned CLOSE_HOLD   = DEF_CLOSE_HOLD,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic in_arrive,
  input  logic in_pass,
  input  logic in_badge_valid,
  input  logic in_badge_is_uni,
  input  logic out_arrive,
  input  logic out_pass,
  input  logic out_badge_valid,
  input  logic out_badge_is_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic in_barrier_open,
  output logic out_barrier_open,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_reject
`ifdef GATE_REJECT_CNT_EN
  ,
  output logic [REJECT_CNT_W-1:0] reject_count
`endif
);

  lane_out_t in_lane;
  lane_out_t out_lane;
  logic      unused_exit_reject;

  gate_lane #(
    .DEBOUNCE     (DEBOUNCE),
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .PULSE_CYCLES (PULSE_CYCLES),
    .CLOSE_HOLD   (CLOSE_HOLD),
    .CNT_W        (CNT_W)
  ) u_in_lane (
    .clk_i          (clk),
    .rst_i          (rst),
    .arrive_i       (in_arrive),
    .pass_i         (in_pass),
    .badge_valid_i  (in_badge_valid),
    .badge_is_uni_i (in_badge_is_uni),
    .uni_vac_i      (uni_is_vacated_space),
    .pub_vac_i      (is_vacated_space),
    .lane_o         (in_lane)
  );

  // Exit lane never rejects: vacancy tied high.
  gate_lane #(
    .DEBOUNCE     (DEBOUNCE),
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .PULSE_CYCLES (PULSE_CYCLES),
    .CLOSE_HOLD   (CLOSE_HOLD),
    .CNT_W        (CNT_W)
  ) u_out_lane (
    .clk_i          (clk),
    .rst_i          (rst),
    .arrive_i       (out_arrive),
    .pass_i         (out_pass),
    .badge_valid_i  (out_badge_valid),
    .badge_is_uni_i (out_badge_is_uni),
    .uni_vac_i      (1'b1),
    .pub_vac_i      (1'b1),
    .lane_o         (out_lane)
  );

  assign in_barrier_open    = in_lane.barrier;
  assign car_entered        = in_lane.evt;
  assign is_uni_car_entered = in_lane.is_uni;
  assign entry_reject       = in_lane.reject;

  assign out_barrier_open   = out_lane.barrier;
  assign car_exited         = out_lane.evt;
  assign is_uni_car_exited  = out_lane.is_uni;
  assign unused_exit_reject = out_lane.reject;

`ifdef GATE_REJECT_CNT_EN
  logic                    rej_prev_q;
  logic [REJECT_CNT_W-1:0] rej_cnt_q, rej_cnt_d;

  // REJECT is only entered from IDLE, so each rise of entry_reject is one refusal.
  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (in_lane.reject && !rej_prev_q && (rej_cnt_q != '1)) begin
      rej_cnt_d = rej_cnt_q + REJECT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rej_prev_q <= 1'b0;
      rej_cnt_q  <= '0;
    end else begin
      rej_prev_q <= in_lane.reject;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  assign reject_count = rej_cnt_q;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed self-checking bench for parking_gate_ctrl (default parameters).
`timescale 1ns/1ps
module tb_parking_gate_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_arrive = 1'b0, in_pass = 1'b0, in_badge_valid = 1'b0, in_badge_is_uni = 1'b0;
  logic out_arrive = 1'b0, out_pass = 1'b0, out_badge_valid = 1'b0, out_badge_is_uni = 1'b0;
  logic uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
  logic in_barrier_open, out_barrier_open, car_entered, is_uni_car_entered;
  logic car_exited, is_uni_car_exited, entry_reject;
`ifdef GATE_REJECT_CNT_EN
  logic [15:0] reject_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_arrive            (in_arrive),
    .in_pass              (in_pass),
    .in_badge_valid       (in_badge_valid),
    .in_badge_is_uni      (in_badge_is_uni),
    .out_arrive           (out_arrive),
    .out_pass             (out_pass),
    .out_badge_valid      (out_badge_valid),
    .out_badge_is_uni     (out_badge_is_uni),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .in_barrier_open      (in_barrier_open),
    .out_barrier_open     (out_barrier_open),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .entry_reject         (entry_reject)
`ifdef GATE_REJECT_CNT_EN
    ,
    .reject_count         (reject_count)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_checks++; if (in_barrier_open !== 1'b0) begin n_fail++; $display("FAIL reset_in_barrier got=%b exp=0", in_barrier_open); end
    n_checks++; if (out_barrier_open !== 1'b0) begin n_fail++; $display("FAIL reset_out_barrier got=%b exp=0", out_barrier_open); end
    n_checks++; if (car_entered !== 1'b0) begin n_fail++; $display("FAIL reset_car_entered got=%b exp=0", car_entered); end
    n_checks++; if (car_exited !== 1'b0) begin n_fail++; $display("FAIL reset_car_exited got=%b exp=0", car_exited); end
    n_checks++; if (is_uni_car_entered !== 1'b0 || is_uni_car_exited !== 1'b0) begin
      n_fail++; $display("FAIL reset_qualifiers got=%b%b exp=00", is_uni_car_entered, is_uni_car_exited);
    end
    n_checks++; if (entry_reject !== 1'b0) begin n_fail++; $display("FAIL reset_entry_reject got=%b exp=0", entry_reject); end
`ifdef GATE_REJECT_CNT_EN
    n_checks++; if (reject_count !== 16'd0) begin n_fail++; $display("FAIL reset_reject_count got=%0d exp=0", reject_count); end
`endif
  endtask

  task automatic test_debounce();
    uni_is_vacated_space = 1'b1;
    is_vacated_space     = 1'b1;
    // 3-cycle glitch must not flip the debounced arrive
    in_arrive = 1'b1;
    tick(3);
    in_arrive = 1'b0;
    tick(2);
    in_badge_valid = 1'b1; in_badge_is_uni = 1'b1;
    tick(1);
    in_badge_valid = 1'b0;
    tick(1);
    n_checks++; if (in_barrier_open !== 1'b0) begin n_fail++; $display("FAIL debounce_glitch barrier got=%b exp=0", in_barrier_open); end
    // held arrive: badge sampled at 4th edge is still too early, at 5th edge it is accepted
    in_arrive = 1'b1;
    tick(3);
    in_badge_valid = 1'b1;
    tick(1);
    in_badge_valid = 1'b0;
    n_checks++; if (in_barrier_open !== 1'b0) begin n_fail++; $display("FAIL debounce_early barrier got=%b exp=0", in_barrier_open); end
    in_badge_valid = 1'b1;
    tick(1);
    in_badge_valid = 1'b0;
    n_checks++; if (in_barrier_open !== 1'b1) begin n_fail++; $display("FAIL debounce_on_time barrier got=%b exp=1", in_barrier_open); end
    // reset while OPEN drops the barrier on the next cycle
    rst = 1'b1; in_arrive = 1'b0;
    tick(1);
    rst = 1'b0;
    n_checks++; if (in_barrier_open !== 1'b0) begin n_fail++; $display("FAIL debounce_reset_open barrier got=%b exp=0", in_barrier_open); end
    tick(2);
  endtask

  task automatic test_entry_uni();
    int  n;
    bit  bad;
    logic q_prev;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    in_arrive = 1'b1;
    tick(5);
    in_badge_valid = 1'b1; in_badge_is_uni = 1'b1;
    tick(1);
    in_badge_valid = 1'b0; in_badge_is_uni = 1'b0;
    n_checks++; if (in_barrier_open !== 1'b1) begin n_fail++; $display("FAIL entry_open barrier got=%b exp=1", in_barrier_open); end
    n_checks++; if (is_uni_car_entered !== 1'b0) begin n_fail++; $display("FAIL entry_open qualifier got=%b exp=0", is_uni_car_entered); end
    in_pass = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (car_entered !== 1'b0 || in_barrier_open !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL entry_passing early_event_or_barrier got=1 exp=0"); end
    n_checks++; if (is_uni_car_entered !== 1'b1) begin n_fail++; $display("FAIL entry_passing qualifier got=%b exp=1", is_uni_car_entered); end
    in_pass = 1'b0;
    n = 0; q_prev = is_uni_car_entered;
    while (car_entered !== 1'b1 && n < 50) begin
      q_prev = is_uni_car_entered;
      tick(1);
      n++;
    end
    n_checks++; if (n >= 50) begin n_fail++; $display("FAIL entry_event_timeout waited=%0d exp<50", n); end
    n_checks++; if (q_prev !== 1'b1) begin n_fail++; $display("FAIL entry_qual_before_pulse got=%b exp=1", q_prev); end
    n = 0; bad = 1'b0;
    while (car_entered === 1'b1 && n < 10) begin
      if (in_barrier_open !== 1'b1 || is_uni_car_entered !== 1'b1) bad = 1'b1;
      tick(1);
      n++;
    end
    n_checks++; if (n != 2) begin n_fail++; $display("FAIL entry_pulse_width got=%0d exp=2", n); end
    n_checks++; if (bad) begin n_fail++; $display("FAIL entry_pulse_barrier_qual got=bad exp=barrier1_qual1"); end
    n = 0; bad = 1'b0;
    while (is_uni_car_entered === 1'b1 && n < 20) begin
      if (in_barrier_open !== 1'b0 || car_entered !== 1'b0) bad = 1'b1;
      tick(1);
      n++;
    end
    n_checks++; if (n != 8) begin n_fail++; $display("FAIL entry_close_hold got=%0d exp=8", n); end
    n_checks++; if (bad) begin n_fail++; $display("FAIL entry_close_barrier got=raised exp=0"); end
    in_arrive = 1'b0;
    tick(6);
  endtask

  task automatic test_reject();
    bit bad;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
    in_arrive = 1'b1;
    tick(5);
    in_badge_valid = 1'b1; in_badge_is_uni = 1'b0;
    tick(1);
    in_badge_valid = 1'b0;
    n_checks++; if (entry_reject !== 1'b1) begin n_fail++; $display("FAIL reject_lit got=%b exp=1", entry_reject); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_barrier_open !== 1'b0 || car_entered !== 1'b0) bad = 1'b1;
      tick(1);
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL reject_no_motion got=moved exp=still"); end
    in_arrive = 1'b0;
    tick(4);
    n_checks++; if (entry_reject !== 1'b1) begin n_fail++; $display("FAIL reject_hold got=%b exp=1", entry_reject); end
    tick(1);
    n_checks++; if (entry_reject !== 1'b0) begin n_fail++; $display("FAIL reject_release got=%b exp=0", entry_reject); end
`ifdef GATE_REJECT_CNT_EN
    n_checks++; if (reject_count !== 16'd1) begin n_fail++; $display("FAIL reject_count got=%0d exp=1", reject_count); end
`endif
    is_vacated_space = 1'b1;
    tick(2);
  endtask

  task automatic test_exit_timeout();
    int n;
    bit bad;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b0;
    out_arrive = 1'b1;
    tick(5);
    out_badge_valid = 1'b1; out_badge_is_uni = 1'b1;
    tick(1);
    out_badge_valid = 1'b0; out_badge_is_uni = 1'b0;
    n = 0; bad = 1'b0;
    while (out_barrier_open === 1'b1 && n < 1100) begin
      if (car_exited !== 1'b0 || is_uni_car_exited !== 1'b0 || in_barrier_open !== 1'b0) bad = 1'b1;
      tick(1);
      n++;
    end
    n_checks++; if (n != 1000) begin n_fail++; $display("FAIL exit_timeout_open_cycles got=%0d exp=1000", n); end
    n_checks++; if (bad) begin n_fail++; $display("FAIL exit_timeout_spurious got=event_or_qual exp=none"); end
    out_arrive = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (car_exited !== 1'b0 || out_barrier_open !== 1'b0) bad = 1'b1;
      tick(1);
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL exit_timeout_close got=event_or_open exp=none"); end
  endtask

  task automatic test_back_to_back();
    int n;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    in_arrive = 1'b1; out_arrive = 1'b1;
    tick(5);
    in_badge_valid = 1'b1;  in_badge_is_uni = 1'b0;
    out_badge_valid = 1'b1; out_badge_is_uni = 1'b1;
    tick(1);
    in_badge_valid = 1'b0; out_badge_valid = 1'b0; out_badge_is_uni = 1'b0;
    in_pass = 1'b1; out_pass = 1'b1;
    tick(10);
    in_pass = 1'b0; out_pass = 1'b0;
    n = 0;
    while (car_entered !== 1'b1 && car_exited !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    n_checks++; if (car_entered !== 1'b1 || car_exited !== 1'b1) begin
      n_fail++; $display("FAIL b2b_simultaneous got=%b%b exp=11", car_entered, car_exited);
    end
    n_checks++; if (is_uni_car_entered !== 1'b0 || is_uni_car_exited !== 1'b1) begin
      n_fail++; $display("FAIL b2b_qualifiers got=%b%b exp=01", is_uni_car_entered, is_uni_car_exited);
    end
    tick(1);
    n_checks++; if (car_entered !== 1'b1 || car_exited !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_cycle got=%b%b exp=11", car_entered, car_exited);
    end
    tick(1);
    n_checks++; if (car_entered !== 1'b0 || car_exited !== 1'b0 || in_barrier_open !== 1'b0 || out_barrier_open !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end got=%b%b%b%b exp=0000", car_entered, car_exited, in_barrier_open, out_barrier_open);
    end
    in_arrive = 1'b0; out_arrive = 1'b0;
    tick(12);
  endtask

  task automatic test_reset_in_event();
    int n;
    bit bad;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    in_arrive = 1'b1;
    tick(5);
    in_badge_valid = 1'b1; in_badge_is_uni = 1'b1;
    tick(1);
    in_badge_valid = 1'b0; in_badge_is_uni = 1'b0;
    in_pass = 1'b1;
    tick(6);
    in_pass = 1'b0;
    n = 0;
    while (car_entered !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    n_checks++; if (n >= 30) begin n_fail++; $display("FAIL rst_event_reach waited=%0d exp<30", n); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++; if (car_entered !== 1'b0 || in_barrier_open !== 1'b0 || is_uni_car_entered !== 1'b0) begin
      n_fail++; $display("FAIL rst_event_drop got=%b%b%b exp=000", car_entered, in_barrier_open, is_uni_car_entered);
    end
`ifdef GATE_REJECT_CNT_EN
    n_checks++; if (reject_count !== 16'd0) begin n_fail++; $display("FAIL rst_reject_count got=%0d exp=0", reject_count); end
`endif
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (car_entered !== 1'b0 || in_barrier_open !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL rst_event_after got=event_or_open exp=none"); end
    in_arrive = 1'b0;
    tick(6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce();
    test_entry_uni();
    test_reject();
    test_exit_timeout();
    test_back_to_back();
    test_reset_in_event();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
